// File: rtl/lola_alu_pkg.sv
// Shared definitions for the Lola ALU control path.
// Holds the datapath width and register count, the 4-bit ALU opcode values,
// the bit offsets of the fields in the 17-bit instruction word
// {op, dst, srca, srcb, imm_en, imm}, and the sequencer state encoding.
package lola_alu_pkg;

    localparam int LOLA_W     = 6;
    localparam int LOLA_NREG  = 4;
    localparam int INSTR_W    = 17;

    // ALU opcodes
    localparam logic [3:0] OP_NOT  = 4'd0;
    localparam logic [3:0] OP_IO   = 4'd1;
    localparam logic [3:0] OP_EQ   = 4'd2;
    localparam logic [3:0] OP_NE   = 4'd3;
    localparam logic [3:0] OP_GT   = 4'd4;
    localparam logic [3:0] OP_GE   = 4'd5;
    localparam logic [3:0] OP_LT   = 4'd6;
    localparam logic [3:0] OP_LE   = 4'd7;
    localparam logic [3:0] OP_INC  = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XOR  = 4'd13;
    localparam logic [3:0] OP_AND  = 4'd14;
    localparam logic [3:0] OP_OR   = 4'd15;

    // Instruction field offsets (LSB of each field)
    localparam int OP_LSB     = 13;
    localparam int DST_LSB    = 11;
    localparam int SRCA_LSB   = 9;
    localparam int SRCB_LSB   = 7;
    localparam int IMM_EN_BIT = 6;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_IO    = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_t;

    // Assemble an instruction word from its fields.
    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [3:0] op,
        input logic [1:0] dst,
        input logic [1:0] srca,
        input logic [1:0] srcb,
        input logic       imm_en,
        input logic [5:0] imm
    );
        return {op, dst, srca, srcb, imm_en, imm};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer.
// NREG entries of W bits, one synchronous write port and three asynchronous
// read ports: operand A, operand B, and the debug read port.
// Ports:
//   clk, rst (async active-low)
//   we, waddr, wdata         write port
//   ra_addr/ra_data          operand A read
//   rb_addr/rb_data          operand B read
//   rd_addr/rd_data          debug read
module alu_regfile #(
    parameter int W     = 6,
    parameter int NREG  = 4,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [IDX_W-1:0] ra_addr,
    output logic [W-1:0]     ra_data,
    input  logic [IDX_W-1:0] rb_addr,
    output logic [W-1:0]     rb_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0] regs_r [NREG];

    // Storage: cleared on reset, written when we is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {W{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end else begin
            regs_r[waddr] <= regs_r[waddr];
        end
    end

    assign ra_data = regs_r[ra_addr];
    assign rb_data = regs_r[rb_addr];
    assign rd_data = regs_r[rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Upstream control stage for the 6-bit Lola ALU.
// Accepts one instruction at a time over instr_valid/instr_ready, captures
// the operands into the registered alu_x/alu_y/alu_op outputs, then uses the
// ALU response (alu_z/alu_baf/alu_iof/alu_zf) one cycle later to write back,
// hand an IO word to the io_valid/io_ready sink, or enter a sticky fault
// that only fault_clr releases.
// Ports:
//   clk, rst (async active-low)
//   instr_valid/instr_ready/instr   instruction handshake
//   alu_x/alu_y/alu_op              registered ALU operands and opcode
//   alu_z/alu_baf/alu_iof/alu_zf    ALU response
//   io_valid/io_ready/io_data       IO word handshake
//   zf, fault, fault_clr, done      status
//   rd_sel/rd_data                  debug register read (combinational)
module alu_sequencer
    import lola_alu_pkg::*;
#(
    parameter int W    = LOLA_W,
    parameter int NREG = LOLA_NREG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [W-1:0]       alu_x,
    output logic [W-1:0]       alu_y,
    output logic [3:0]         alu_op,
    input  logic [W-1:0]       alu_z,
    input  logic               alu_baf,
    input  logic               alu_iof,
    input  logic               alu_zf,
    output logic               io_valid,
    input  logic               io_ready,
    output logic [W-1:0]       io_data,
    output logic               zf,
    output logic               fault,
    input  logic               fault_clr,
    output logic               done,
    input  logic [1:0]         rd_sel,
    output logic [W-1:0]       rd_data
);

    seq_state_t state_r;
    seq_state_t next_state_s;

    logic [W-1:0] alu_x_r;
    logic [W-1:0] alu_y_r;
    logic [3:0]   alu_op_r;
    logic [1:0]   dst_r;
    logic         zf_r;
    logic         fault_r;
    logic         done_r;
    logic         io_valid_r;
    logic         we_s;

    // Instruction field decode
    logic [3:0]   f_op_s;
    logic [1:0]   f_srca_s;
    logic [1:0]   f_srcb_s;
    logic [1:0]   f_dst_s;
    logic         f_imm_en_s;
    logic [W-1:0] f_imm_s;
    logic [W-1:0] ra_data_s;
    logic [W-1:0] rb_data_s;

    assign f_op_s     = instr[OP_LSB +: 4];
    assign f_dst_s    = instr[DST_LSB +: 2];
    assign f_srca_s   = instr[SRCA_LSB +: 2];
    assign f_srcb_s   = instr[SRCB_LSB +: 2];
    assign f_imm_en_s = instr[IMM_EN_BIT];
    assign f_imm_s    = instr[IMM_LSB +: W];

    alu_regfile #(
        .W    (W),
        .NREG (NREG),
        .IDX_W(2)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (we_s),
        .waddr  (dst_r),
        .wdata  (alu_z),
        .ra_addr(f_srca_s),
        .ra_data(ra_data_s),
        .rb_addr(f_srcb_s),
        .rb_data(rb_data_s),
        .rd_addr(rd_sel),
        .rd_data(rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and register-file write enable.
    // EXEC checks the ALU response in priority order: bad operand, IO, writeback.
    always_comb begin
        next_state_s = state_r;
        we_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (alu_baf) begin
                    next_state_s = ST_FAULT;
                end else if (alu_iof) begin
                    next_state_s = ST_IO;
                end else begin
                    next_state_s = ST_IDLE;
                    we_s         = 1'b1;
                end
            end
            ST_IO: begin
                if (io_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IO;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, flags, IO handshake and retire pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_x_r    <= {W{1'b0}};
            alu_y_r    <= {W{1'b0}};
            alu_op_r   <= 4'd0;
            dst_r      <= 2'd0;
            zf_r       <= 1'b0;
            fault_r    <= 1'b0;
            done_r     <= 1'b0;
            io_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        // Operands are captured here, so a later write to
                        // srca/srcb (including dst==src) cannot disturb them.
                        alu_x_r  <= ra_data_s;
                        alu_y_r  <= f_imm_en_s ? f_imm_s : rb_data_s;
                        alu_op_r <= f_op_s;
                        dst_r    <= f_dst_s;
                    end
                end
                ST_EXEC: begin
                    if (alu_baf) begin
                        fault_r <= 1'b1;
                    end else if (alu_iof) begin
                        io_valid_r <= 1'b1;
                    end else begin
                        zf_r   <= alu_zf;
                        done_r <= 1'b1;
                    end
                end
                ST_IO: begin
                    if (io_ready) begin
                        io_valid_r <= 1'b0;
                        done_r     <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        fault_r <= 1'b0;
                    end
                end
                default: begin
                    io_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready = (state_r == ST_IDLE);
    assign alu_x       = alu_x_r;
    assign alu_y       = alu_y_r;
    assign alu_op      = alu_op_r;
    assign io_valid    = io_valid_r;
    // alu_x_r is frozen outside IDLE, so the IO word stays stable until taken.
    assign io_data     = alu_x_r;
    assign zf          = zf_r;
    assign fault       = fault_r;
    assign done        = done_r;

endmodule
